// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and sizing constants for the shift-add multiplier controller
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int ITER_W = $clog2(MULT_WIDTH);
  typedef enum logic [2:0] {IDLE, INIT, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt: iteration counter that saturates at WIDTH-1 and flags the final iteration
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Clear,
  input  logic                     Inc,
  output logic [$clog2(WIDTH)-1:0] Count,
  output logic                     Last
);
  localparam int CW = $clog2(WIDTH);
  assign Last = Count == CW'(WIDTH - 1);
  // count iterations; holding at the terminal value keeps the index wrap-free
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) Count <= '0;
    else if (Clear) Count <= '0;
    else if (Inc && !Last) Count <= Count + CW'(1);
endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: Moore controller sequencing a WIDTH-iteration shift-add multiplier datapath
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic                     Signed,
  input  logic                     M_Lsb,
  input  logic                     Resp_Ready,
  input  logic                     Acc_Msb,
  output logic                     Busy,
  output logic                     Clear_A,
  output logic                     Load_B,
  output logic                     Load_M,
  output logic                     Add_En,
  output logic                     Sub,
  output logic                     Shift_En,
  output logic                     Shift_In,
  output logic                     Sign_Ext,
  output logic [$clog2(WIDTH)-1:0] Count,
  output logic                     Valid
);
  state_t state, nextState;
  logic lastIter;
  mult_iter_cnt #(.WIDTH(WIDTH)) iterCnt (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Clear  (state == IDLE || state == INIT),
    .Inc    (state == SHIFT),
    .Count  (Count),
    .Last   (lastIter)
  );
  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= nextState;
  // operand mode is frozen at acceptance so a changing Signed input cannot corrupt a run
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) Sign_Ext <= 1'b0;
    else if (state == IDLE && Start) Sign_Ext <= Signed;
  // next-state and datapath strobes; the final signed iteration subtracts the sign-weighted partial product
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = Start ? INIT : IDLE;
      INIT:    nextState = ADD;
      ADD:     nextState = SHIFT;
      SHIFT:   nextState = lastIter ? DONE : ADD;
      DONE:    nextState = Resp_Ready ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
    Busy     = state != IDLE;
    Clear_A  = state == INIT;
    Load_B   = state == INIT;
    Load_M   = state == INIT;
    Add_En   = state == ADD && M_Lsb;
    Sub      = state == ADD && M_Lsb && Sign_Ext && lastIter;
    Shift_En = state == SHIFT;
    Shift_In = Sign_Ext & Acc_Msb;
    Valid    = state == DONE;
  end
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: drives mult_ctrl against a behavioural shift-add datapath and scores the products
module tb_mult_ctrl;
  import mult_pkg::*;
  logic Clk = 0, Reset_n = 0, Start = 0, Signed = 0, Resp_Ready = 0;
  logic M_Lsb, Acc_Msb;
  logic Busy, Clear_A, Load_B, Load_M, Add_En, Sub, Shift_En, Shift_In, Sign_Ext, Valid;
  logic [4:0] Count;

  mult_ctrl #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Signed(Signed), .M_Lsb(M_Lsb),
    .Resp_Ready(Resp_Ready), .Acc_Msb(Acc_Msb), .Busy(Busy), .Clear_A(Clear_A),
    .Load_B(Load_B), .Load_M(Load_M), .Add_En(Add_En), .Sub(Sub), .Shift_En(Shift_En),
    .Shift_In(Shift_In), .Sign_Ext(Sign_Ext), .Count(Count), .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  logic [32:0] accReg = '0;
  logic [31:0] mplReg = '0, mcdReg = '0, opM = '0, opB = '0;
  logic [32:0] ext;
  assign ext = Sign_Ext ? {mcdReg[31], mcdReg} : {1'b0, mcdReg};
  assign M_Lsb = mplReg[0];
  assign Acc_Msb = accReg[32];

  // external datapath reacting to the controller strobes
  always @(posedge Clk) begin
    if (Clear_A) accReg <= '0;
    if (Load_B) mplReg <= opB;
    if (Load_M) mcdReg <= opM;
    if (Add_En) accReg <= Sub ? accReg - ext : accReg + ext;
    if (Shift_En) {accReg, mplReg} <= {Shift_In, accReg, mplReg[31:1]};
  end

  int assertBad = 0, shiftInBad = 0, initCnt = 0, seqBad = 0, expIter = 0;
  logic [31:0] addMask = '0, subMask = '0;

  // invariant and per-iteration monitor
  always @(negedge Clk) if (Reset_n) begin
    if ((Add_En && Shift_En) || (Sub && !Add_En) || (Busy != (dut.state != IDLE)) ||
        (Valid && Count != 5'd31)) assertBad++;
    if (Shift_In !== (Sign_Ext & Acc_Msb)) shiftInBad++;
    if (Clear_A) begin
      initCnt++; expIter = 0; seqBad = 0; addMask = '0; subMask = '0;
    end
    if (Busy && !Clear_A && !Shift_En && !Valid) begin
      addMask[Count] = Add_En; subMask[Count] = Sub;
    end
    if (Shift_En) begin
      if (Count != 5'(expIter)) seqBad++;
      expIter++;
    end
  end

  typedef struct {
    logic        sgn;
    logic [31:0] m;
    logic [31:0] b;
    logic [63:0] prod;
    int          delay;
    bit          pulse;
  } vec_t;

  vec_t vecs[9];
  logic [63:0] q[$];
  int nVec = 0, nBad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input string nm, input bit b2b);
    int lat;
    bit holdBad;
    logic [63:0] exp;
    initCnt = 0;
    opM = v.m; opB = v.b; Signed = v.sgn; Start = 1;
    q.push_back(v.prod);
    @(negedge Clk);
    Start = 0; lat = 1;
    check({nm, " init"}, {Clear_A, Load_B, Load_M, Busy, Sign_Ext, Add_En, Shift_En, Count},
          {1'b1, 1'b1, 1'b1, 1'b1, v.sgn, 1'b0, 1'b0, 5'd0});
    while (!Valid && lat < 300) begin
      Start = v.pulse && (lat == 10 || lat == 40);
      @(negedge Clk);
      lat++;
    end
    Start = 0;
    check({nm, " latency"}, 64'(lat), 64'd66);
    exp = q.size() > 0 ? q.pop_front() : 'x;
    check({nm, " product"}, {accReg[31:0], mplReg}, exp);
    check({nm, " count seq"}, {32'(seqBad), 32'(expIter)}, {32'd0, 32'd32});
    check({nm, " init once"}, 64'(initCnt), 64'd1);
    holdBad = 0;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge Clk);
      if (!Valid || !Busy) holdBad = 1;
    end
    check({nm, " hold"}, 64'(holdBad), 64'd0);
    Resp_Ready = 1; Start = b2b;
    @(negedge Clk);
    Resp_Ready = 0;
    check({nm, " idle"}, {Busy, Valid, Clear_A}, 3'b000);
  endtask

  initial begin
    int n;
    vecs = '{
      '{1'b0, 32'd3,         32'd5,         64'd15,                  0,  1'b0},
      '{1'b1, 32'hFFFFFFFF,  32'h80000000,  64'h0000_0000_8000_0000, 0,  1'b0},
      '{1'b0, 32'd7,         32'd9,         64'd63,                  10, 1'b0},
      '{1'b1, 32'hFFFFFFFD,  32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 0,  1'b1},
      '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFF_FFFE_0000_0001, 2,  1'b0},
      '{1'b1, 32'd5,         32'hFFFFFFF9,  64'hFFFF_FFFF_FFFF_FFDD, 0,  1'b0},
      '{1'b1, 32'h80000000,  32'h80000000,  64'h4000_0000_0000_0000, 1,  1'b0},
      '{1'b0, 32'd0,         32'h12345678,  64'd0,                   0,  1'b0},
      '{1'b1, 32'h12345678,  32'hFFFFFFFF,  64'hFFFF_FFFF_EDCB_A988, 0,  1'b0}
    };
    Start = 1;
    repeat (3) @(negedge Clk);
    check("reset state", {Busy, Valid, Clear_A, Load_B, Load_M, Add_En, Sub, Shift_En, Sign_Ext, Count}, '0);
    Start = 0;
    Reset_n = 1;
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i), i == 3);
      if (i == 0) check("vec0 add mask", addMask, 64'h5);
      if (i == 1) check("vec1 sub mask", subMask, 64'h8000_0000);
    end
    opM = 32'hFFFFFFFD; opB = 32'd7; Signed = 1; Start = 1;
    @(negedge Clk);
    Start = 0; n = 0;
    while (Count != 5'd10 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("abort reached iter 10", 64'(Count), 64'd10);
    Reset_n = 0;
    #1;
    check("abort outputs", {Busy, Valid, Clear_A, Load_B, Load_M, Add_En, Sub, Shift_En, Sign_Ext, Shift_In, Count}, '0);
    Start = 1;
    @(negedge Clk);
    check("reset held", {Busy, Valid, Clear_A, Sign_Ext, Count}, '0);
    Start = 0;
    Reset_n = 1;
    do_op('{1'b0, 32'd7, 32'd9, 64'd63, 0, 1'b0}, "post-reset", 1'b0);
    check("invariants", 64'(assertBad), 64'd0);
    check("shift-in tracking", 64'(shiftInBad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; the accumulator register is WIDTH+1 bits.
REQ-002 SHALL have port Clk  in  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start  in  1  request; accepted only in IDLE.
REQ-005 SHALL have port Signed  in  1  operand mode; captured at Start acceptance.
REQ-006 SHALL have port M_Lsb  in  1  current bit 0 of the multiplier shift register.
REQ-007 SHALL have port Resp_Ready  in  1  consumer ready for the result.
REQ-008 SHALL have port Busy  out  1  high in any state other than IDLE.
REQ-009 SHALL have port Clear_A  out  1  synchronous clear of the accumulator register.
REQ-010 SHALL have port Load_B  out  1  load multiplier register.
REQ-011 SHALL have port Load_M  out  1  load multiplicand register.
REQ-012 SHALL have port Add_En  out  1  load the accumulator from the adder.
REQ-013 SHALL have port Sub  out  1  adder subtracts the multiplicand.
REQ-014 SHALL have port Shift_En  out  1  right-shift the accumulator:multiplier pair.
REQ-015 SHALL have port Shift_In  out  1  accumulator MSB shift-in; equals Sign_Ext AND accumulator MSB.
REQ-016 SHALL have port Acc_Msb  in  1  accumulator bit WIDTH.
REQ-017 SHALL have port Sign_Ext  out  1  latched Signed; selects sign- or zero-extension of the multiplicand into the adder.
REQ-018 SHALL have port Count  out  $clog2(WIDTH)  current iteration index.
REQ-019 SHALL have port Valid  out  1  product registers hold the final result.

Function
REQ-020 SHALL implement Moore states IDLE, INIT, ADD, SHIFT and DONE.
REQ-021 SHALL transition IDLE->INIT when Start=1, latching Signed into Sign_Ext.
REQ-022 SHALL assert Clear_A, Load_B and Load_M for exactly one cycle in INIT, set Count=0, then go to ADD.
REQ-023 SHALL assert Add_En in ADD iff M_Lsb=1, then go to SHIFT.
REQ-024 SHALL assert Sub in ADD iff Sign_Ext=1 and Count=WIDTH-1 and M_Lsb=1.
REQ-025 SHALL assert Shift_En for one cycle in SHIFT, then go to DONE if Count=WIDTH-1, else increment Count and go to ADD.
REQ-026 SHALL give fixed latency: Start sampled at edge 0, INIT in cycle 1, ADD/SHIFT pairs in cycles 2..2*WIDTH+1, Valid first high in cycle 2*WIDTH+2 (66 for WIDTH=32), independent of operand values.
REQ-027 SHALL hold Valid=1 in DONE until Resp_Ready=1 is sampled, then go to IDLE; Valid SHALL be low in IDLE.
REQ-028 SHALL ignore Start in every non-IDLE state, with no side effects.
REQ-029 SHALL complete the IDLE acceptance for Start and Resp_Ready arriving in the same cycle as the DONE->IDLE transition only on the following cycle; there is no back-to-back bypass.
REQ-030 SHALL keep Add_En and Shift_En mutually exclusive in every cycle; Sub SHALL imply Add_En.
REQ-031 SHALL make Count wrap-free: it never exceeds WIDTH-1 and stops incrementing once it reaches WIDTH-1.

Reset
REQ-032 SHALL drive, while Reset_n=0: state=IDLE, Count=0, Sign_Ext=0, and Busy, Valid, Clear_A, Load_B, Load_M, Add_En, Sub, Shift_En all 0.
REQ-033 SHALL abort any operation in progress on reset assertion mid-operation, with no residual strobes after deassertion.
REQ-034 SHALL accept Start on the first rising edge after Reset_n deasserts.

Structure
REQ-035 SHALL define in shared package mult_pkg: the state enum, MULT_WIDTH=32 and the ITER_W constant.
REQ-036 SHALL implement the iteration counter as sub-module mult_iter_cnt (clear, increment, terminal-count flag).

Verification
REQ-037 SHALL cover unsigned 3x5, with M_Lsb modelled from B=5: Add_En high in the ADD cycles of iterations 0 and 2 only; Valid at cycle 66; product 15.
REQ-038 SHALL cover signed (-1)x(0x80000000): Sub high only in iteration 31; Shift_In follows Acc_Msb; product 0x0000_0000_8000_0000.
REQ-039 SHALL cover Start pulsed at cycles 10 and 40 during an operation: no INIT re-entry, Count sequence unchanged.
REQ-040 SHALL cover Resp_Ready held low for 10 cycles after Valid: Valid and DONE held throughout; IDLE the cycle after Resp_Ready=1.
REQ-041 SHALL cover Reset_n pulsed low at iteration 10: all outputs 0 immediately; a new Start after release yields a correct 7x9=63.
REQ-042 SHALL cover the assertion checks: Add_En and Shift_En never both high; Busy equals the inverse of (state==IDLE); Count never exceeds 31.
